cmp_pulse_meter: RTL and testbench

Digital back-end for the comparator/opamp stage. Takes the comparator's single-bit output as an asynchronous level, synchronises it and glitch-filters it. It then measures the duration of every high and low interval in clock cycles and queues each measurement in a small FIFO, read out over a valid/ready interface. It sits directly downstream of the opamp digitiser and feeds the measurement/analysis logic.

---
 rtl/cmp_meas_pkg.sv | 23 ++
 rtl/meas_fifo.sv | 70 +++++++
 rtl/cmp_pulse_meter.sv | 139 +++++++++++++
 tb/tb_cmp_pulse_meter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_meas_pkg.sv
// rtl/cmp_meas_pkg.sv - shared state type and entry layout helpers for the pulse meter
package cmp_meas_pkg;

  // Measurement sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } meas_state_e;

  localparam int DEF_CNT_W = 16;

  // An entry is the duration field with the interval level stacked on top
  function automatic int entry_w(input int cnt_w);
    return cnt_w + 1;
  endfunction

  // Bit position of the interval level inside an entry
  function automatic int lvl_bit(input int cnt_w);
    return cnt_w;
  endfunction

endpackage

// File: rtl/meas_fifo.sv
// rtl/meas_fifo.sv - synchronous measurement FIFO with a registered head entry
module meas_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    rd_next;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_pop, do_push;

  // Pointer/count bookkeeping; a push into a full FIFO is taken only when a pop frees the slot
  always_comb begin
    full     = (count_q == (AW+1)'(DEPTH));
    empty    = (count_q == '0);
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    rd_next  = rd_ptr_q + 1'b1;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_next : rd_ptr_q;
    count_d  = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    // The head must hold the oldest live entry right after the edge, including the
    // case where the incoming entry becomes the only one
    head_d   = head_q;
    if (do_push && (empty || (do_pop && count_q == (AW+1)'(1)))) begin
      head_d = push_data;
    end else if (do_pop && count_q > (AW+1)'(1)) begin
      head_d = mem_q[rd_next];
    end
  end

  // Entry storage; contents need no reset because the count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Control and head registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign head = head_q;

endmodule

// File: rtl/cmp_pulse_meter.sv
// rtl/cmp_pulse_meter.sv - comparator synchroniser, glitch filter and interval duration meter
module cmp_pulse_meter
  import cmp_meas_pkg::*;
#(
  parameter int FILT_LEN   = 4,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmp_in,
  input  logic             enable,
  input  logic             clr_ovf,
  output logic             level_o,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W:0]   m_data,
  output logic             ovf
);

  localparam int ENTRY_W = entry_w(CNT_W);
  localparam int LVL_BIT = lvl_bit(CNT_W);
  localparam int RUN_W   = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               level_q, level_d;
  logic               edge_det;
  meas_state_e        state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               push;
  logic [ENTRY_W-1:0] push_data;
  logic               fifo_full, fifo_empty, pop;
  logic [ENTRY_W-1:0] fifo_head;

  // Synchroniser, run-length glitch filter and measurement sequencer next state
  always_comb begin
    sync1_d  = cmp_in;
    sync2_d  = sync1_q;
    run_d    = '0;
    level_d  = level_q;
    edge_det = 1'b0;
    if (sync2_q != level_q) begin
      if (run_q == RUN_W'(FILT_LEN - 1)) begin
        level_d  = ~level_q;
        edge_det = 1'b1;
      end else begin
        run_d = run_q + 1'b1;
      end
    end

    state_d = state_q;
    count_d = count_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (enable) state_d = ARMED;
      end
      // The interval in progress at arm time has an unknown start, so it is dropped
      ARMED: begin
        if (edge_det) begin
          count_d = CNT_W'(1);
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (edge_det) begin
          push    = 1'b1;
          count_d = CNT_W'(1);
        end else if (count_q != '1) begin
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!enable) begin
      state_d = IDLE;
      count_d = '0;
      push    = 1'b0;
    end

    push_data          = '0;
    push_data[LVL_BIT] = level_q;
    push_data[CNT_W-1:0] = count_q;
  end

  // Sticky drop flag; a drop in the same cycle as a clear must still be reported
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (push && fifo_full && !pop) ovf_d = 1'b1;
  end

  // All block state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      run_q   <= '0;
      level_q <= 1'b0;
      state_q <= IDLE;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      run_q   <= run_d;
      level_q <= level_d;
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pop = ~fifo_empty & m_ready;

  meas_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign level_o = level_q;
  assign m_valid = ~fifo_empty;
  assign m_data  = fifo_head;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_cmp_pulse_meter.sv
// tb/tb_cmp_pulse_meter.sv - self-checking bench for cmp_pulse_meter
module tb_cmp_pulse_meter;

  localparam int FL  = 4;
  localparam int CW  = 8;
  localparam int FD  = 8;
  localparam int SAT = 255;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmp_in = 1'b0;
  logic          enable = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          m_ready = 1'b0;
  logic          level_o, m_valid, ovf;
  logic [CW:0]   m_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cmp_pulse_meter #(
    .FILT_LEN   (FL),
    .CNT_W      (CW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmp_in  (cmp_in),
    .enable  (enable),
    .clr_ovf (clr_ovf),
    .level_o (level_o),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .ovf     (ovf)
  );

  // Reference model: cycle-indexed history and timestamps
  bit          cmp_hist[$];
  bit          sync_hist[$];
  bit          m_level;
  bit          armed;
  bit          have_ref;
  int          ref_cyc;
  int          cyc;
  logic [CW:0] mq[$];
  bit          m_ovf;

  function automatic logic [CW:0] ent(input bit l, input int d);
    logic [CW:0] e;
    e[CW]     = l;
    e[CW-1:0] = CW'((d > SAT) ? SAT : d);
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    bit sync_cur, edge_now, old_lvl, do_pop, do_push;
    int dur;
    if (!rst_n) begin
      cmp_hist.delete();
      cmp_hist.push_back(1'b0);
      cmp_hist.push_back(1'b0);
      sync_hist.delete();
      mq.delete();
      m_level  = 1'b0;
      armed    = 1'b0;
      have_ref = 1'b0;
      m_ovf    = 1'b0;
      cyc      = 0;
      ref_cyc  = 0;
    end else begin
      cyc++;
      sync_cur = cmp_hist[cmp_hist.size()-2];
      sync_hist.push_back(sync_cur);
      if (sync_hist.size() > FL) void'(sync_hist.pop_front());
      // the level flips once the last FL synchronised samples all disagree with it
      edge_now = (sync_hist.size() == FL);
      foreach (sync_hist[i]) if (sync_hist[i] == m_level) edge_now = 1'b0;
      old_lvl = m_level;
      if (edge_now) m_level = ~m_level;
      do_pop  = (mq.size() > 0) && m_ready;
      do_push = 1'b0;
      dur     = 0;
      if (!enable) begin
        armed    = 1'b0;
        have_ref = 1'b0;
      end else if (!armed) begin
        armed = 1'b1;
      end else if (edge_now) begin
        if (have_ref) begin
          do_push = 1'b1;
          dur     = cyc - ref_cyc;
        end
        ref_cyc  = cyc;
        have_ref = 1'b1;
      end
      if (do_pop) void'(mq.pop_front());
      if (clr_ovf) m_ovf = 1'b0;
      if (do_push) begin
        if (mq.size() < FD) mq.push_back(ent(old_lvl, dur));
        else m_ovf = 1'b1;
      end
      cmp_hist.push_back(cmp_in);
      if (cmp_hist.size() > 2) void'(cmp_hist.pop_front());
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    enable  = 1'b0;
    m_ready = 1'b0;
    clr_ovf = 1'b0;
    cmp_in  = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic toggle_run(input int n, input int per);
    repeat (n) begin
      cmp_in = ~cmp_in;
      repeat (per) tick();
    end
  endtask

  typedef struct {
    int hi;
    int lo;
    int exp_hi;
    int exp_lo;
  } ivec_t;

  typedef struct {
    int plen;
    int exp_tick;
  } gvec_t;

  ivec_t iv[4];
  gvec_t gv[6];

  initial begin
    int found;
    int run_left;
    int off_left;

    iv[0] = '{hi: 50,  lo: 30,  exp_hi: 50,  exp_lo: 30};
    iv[1] = '{hi: 400, lo: 20,  exp_hi: 255, exp_lo: 20};
    iv[2] = '{hi: 4,   lo: 4,   exp_hi: 4,   exp_lo: 4};
    iv[3] = '{hi: 9,   lo: 300, exp_hi: 9,   exp_lo: 255};

    gv[0] = '{plen: 1, exp_tick: 0};
    gv[1] = '{plen: 2, exp_tick: 0};
    gv[2] = '{plen: 3, exp_tick: 0};
    gv[3] = '{plen: 4, exp_tick: 6};
    gv[4] = '{plen: 5, exp_tick: 6};
    gv[5] = '{plen: 8, exp_tick: 6};

    // reset values
    do_reset();
    chk("rst_level", 32'(level_o), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_data",  32'(m_data),  0);
    chk("rst_ovf",   32'(ovf),     0);

    // arm, discard partial interval, then one high and one low interval
    for (int v = 0; v < 4; v++) begin
      do_reset();
      enable = 1'b1;
      tick();
      tick();
      cmp_in = 1'b1;
      repeat (iv[v].hi) tick();
      cmp_in = 1'b0;
      repeat (iv[v].lo) tick();
      cmp_in = 1'b1;
      repeat (FL + 4) tick();
      chk($sformatf("iv%0d_valid0", v), 32'(m_valid), 1);
      chk($sformatf("iv%0d_hi", v), 32'(m_data), 32'(ent(1'b1, iv[v].exp_hi)));
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk($sformatf("iv%0d_valid1", v), 32'(m_valid), 1);
      chk($sformatf("iv%0d_lo", v), 32'(m_data), 32'(ent(1'b0, iv[v].exp_lo)));
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk($sformatf("iv%0d_empty", v), 32'(m_valid), 0);
      chk($sformatf("iv%0d_ovf", v), 32'(ovf), 0);
    end

    // glitch rejection and filter latency
    for (int v = 0; v < 6; v++) begin
      do_reset();
      cmp_in = 1'b1;
      found  = 0;
      for (int t = 1; t <= 14; t++) begin
        if (t == gv[v].plen + 1) cmp_in = 1'b0;
        tick();
        if (found == 0 && level_o) found = t;
      end
      chk($sformatf("glitch_p%0d_tick", gv[v].plen), found, gv[v].exp_tick);
    end

    // overflow with the consumer stalled, then in-order drain at full rate
    do_reset();
    enable = 1'b1;
    tick();
    tick();
    for (int i = 1; i <= 11; i++) begin
      cmp_in = ~cmp_in;
      repeat (6) tick();
      if (i == 9)  chk("ovf_full_clear", 32'(ovf), 0);
      if (i == 10) chk("ovf_set", 32'(ovf), 1);
    end
    m_ready = 1'b1;
    for (int i = 0; i < FD; i++) begin
      chk($sformatf("ovf_drain%0d_valid", i), 32'(m_valid), 1);
      chk($sformatf("ovf_drain%0d_data", i), 32'(m_data), 32'(ent((i % 2) == 0, 6)));
      tick();
    end
    m_ready = 1'b0;
    chk("ovf_drained", 32'(m_valid), 0);
    chk("ovf_sticky", 32'(ovf), 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(ovf), 0);

    // full FIFO with a pop on the same edge as a push
    do_reset();
    enable = 1'b1;
    tick();
    tick();
    toggle_run(9, 6);
    cmp_in = ~cmp_in;
    repeat (5) tick();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("fullpp_level", 32'(level_o), 0);
    chk("fullpp_ovf", 32'(ovf), 0);
    m_ready = 1'b1;
    for (int i = 0; i < FD; i++) begin
      chk($sformatf("fullpp%0d_valid", i), 32'(m_valid), 1);
      chk($sformatf("fullpp%0d_data", i), 32'(m_data), 32'(ent((i % 2) == 1, 6)));
      tick();
    end
    m_ready = 1'b0;
    chk("fullpp_empty", 32'(m_valid), 0);

    // enable drop mid-measure re-arms on the next edge
    do_reset();
    enable = 1'b1;
    tick();
    tick();
    toggle_run(2, 6);
    enable = 1'b0;
    repeat (5) tick();
    enable = 1'b1;
    tick();
    toggle_run(2, 8);
    repeat (4) tick();
    chk("en_e0_valid", 32'(m_valid), 1);
    chk("en_e0_data", 32'(m_data), 32'(ent(1'b1, 6)));
    m_ready = 1'b1;
    tick();
    chk("en_e1_valid", 32'(m_valid), 1);
    chk("en_e1_data", 32'(m_data), 32'(ent(1'b1, 8)));
    tick();
    m_ready = 1'b0;
    chk("en_empty", 32'(m_valid), 0);

    // reset with entries queued
    do_reset();
    enable = 1'b1;
    tick();
    tick();
    toggle_run(4, 6);
    chk("midrst_pre_valid", 32'(m_valid), 1);
    rst_n = 1'b0;
    tick();
    chk("midrst_valid", 32'(m_valid), 0);
    chk("midrst_data", 32'(m_data), 0);
    chk("midrst_ovf", 32'(ovf), 0);
    chk("midrst_level", 32'(level_o), 0);
    rst_n = 1'b1;

    // randomized traffic against the reference model
    do_reset();
    run_left = 0;
    off_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (run_left == 0) begin
        cmp_in   = ~cmp_in;
        run_left = ($urandom_range(0, 19) == 0) ? int'($urandom_range(100, 320))
                                                 : int'($urandom_range(1, 10));
      end
      run_left--;
      if (off_left > 0) begin
        enable = 1'b0;
        off_left--;
      end else begin
        enable = 1'b1;
        if ($urandom_range(0, 299) == 0) off_left = int'($urandom_range(1, 8));
      end
      m_ready = ($urandom_range(0, 2) == 0);
      clr_ovf = ($urandom_range(0, 59) == 0);
      rst_n   = ($urandom_range(0, 1999) != 0);
      tick();
      chk("rnd_level", 32'(level_o), 32'(m_level));
      chk("rnd_valid", 32'(m_valid), 32'(mq.size() > 0));
      chk("rnd_ovf",   32'(ovf),     32'(m_ovf));
      if (mq.size() > 0) chk("rnd_data", 32'(m_data), 32'(mq[0]));
    end
    rst_n   = 1'b1;
    m_ready = 1'b0;
    clr_ovf = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
